jtag_chain_master: RTL and testbench
====================================

// Module: jtag_chain_master
// PURPOSE
// Host-side driver for the Jen/Jin/Jout word scan chain that runs through the
// CPU's instruction and data memories (Imem, then Dmem, 512 words each).
// Streams a memory image into the chain and streams the displaced contents back
// out, so one pass both loads a program and reads back data memory.
// Holds the CPU in reset while a pass is running.
// A recirculate mode rotates the chain onto itself: non-destructive readback.
// PARAMETERS
// WIDTH      32    chain word width (matches Jin/Jout)
// CHAIN_LEN  1024  total words in chain (Imem 512 + Dmem 512)
// CNT_W      11    shift counter width, must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
// clk        in   1      system clock; the chain shifts on rising edges where Jen=1
// rst        in   1      asynchronous, active-low reset
// start      in   1      one-cycle request to begin a pass; ignored while busy
// recirc     in   1      sampled at start: 1 = Jin<=Jout (readback only), 0 = load
// in_data    in   WIDTH  load word from host
// in_valid   in   1      in_data valid
// in_ready   out  1      load word consumed this cycle
// out_data   out  WIDTH  word shifted out of chain tail
// out_valid  out  1      out_data valid
// out_ready  in   1      host accepts out_data
// Jen        out  1      chain shift enable
// Jin        out  WIDTH  word into chain head (Imem[0])
// Jout       in   WIDTH  word at chain tail (Dmem[511]), combinational from chain
// busy       out  1      pass in progress
// cpu_rst    out  1      CPU reset request, equals busy
// done       out  1      one-cycle pulse at end of pass
// shift_cnt  out  CNT_W  shifts completed in current pass
// BEHAVIOUR
// Reset (rst=0, async): state=IDLE; Jen, in_ready, out_valid, busy, cpu_rst, done = 0.
// Reset also sets shift_cnt=0 and out_data=0. The chain contents are untouched.
// States: IDLE -> SHIFT -> DRAIN -> DONE -> IDLE.
// IDLE: start=1 latches recirc, clears shift_cnt, and goes to SHIFT next cycle.
// busy and cpu_rst rise on the cycle after start.
// SHIFT: shift_go = (recirc_q | in_valid) & (~out_valid | out_ready).
// Jen = in_ready = shift_go, with in_ready forced 0 when recirc_q=1.
// Both are combinational and are 0 in every other state.
// Jin = recirc_q ? Jout : in_data.
// On a shift edge: out_data<=Jout (the pre-shift tail), out_valid<=1, shift_cnt++.
// out_valid clears on out_ready handshake unless a new shift refills it that cycle.
// A simultaneous handshake and shift is legal: one word out, one word in.
// When shift_cnt reaches CHAIN_LEN: go to DRAIN; Jen never exceeds CHAIN_LEN per pass.
// DRAIN: wait for the final out handshake, then go to DONE.
// DONE: done=1 for one cycle; busy drops on that same cycle; return to IDLE.
// Order: first word in lands at the tail (Dmem[511]); last word in lands at Imem[0].
// Out stream order matches: Dmem[511] first, Imem[0] last.
// No words are lost or duplicated under any in_valid/out_ready pattern.
// Rest of SHIFT: in_valid gaps or backpressure hold Jen=0, and the chain and counter freeze.
// A start pulse while busy is ignored; recirc changes mid-pass have no effect.
// Reset mid-pass aborts immediately. The chain is left partially shifted (host must reload).
// Throughput: 1 word/cycle sustained. A pass takes CHAIN_LEN+3 cycles, start to done, with no stalls.
// TESTING
// 1. Load words 0..1023, in_valid=out_ready=1 -> Jen high 1024 consecutive cycles.
//    done pulses at cycle 1027 relative to start; busy=cpu_rst=1 from cycle 1 to cycle 1026.
// 2. After test 1, recirc pass -> out stream 0,1,..,1023.
//    A second recirc pass -> identical stream (chain preserved).
// 3. After test 1, load words 0xA000+k -> out stream 0..1023; a recirc pass then yields 0xA000..0xA3FF.
// 4. out_ready toggled 1,0,1,0 -> Jen=0 whenever out_valid&~out_ready.
//    1024 words delivered in order, with no repeats.
// 5. in_valid low for 5 cycles at shift_cnt=300 -> Jen and in_ready=0 for those cycles.
//    shift_cnt stays 300; resumes with no data slip.
// 6. rst=0 at shift_cnt=500 -> Jen, busy, out_valid, done=0 asynchronously.
//    A new start then restarts at shift_cnt=0; a start pulse during busy has no effect.

Source files
------------

// File: rtl/jtag_chain_master_if.sv
// Host load/readback streams plus the Jen/Jin/Jout word chain, bundled for the chain master.
// master = chain master side, slave = host and chain side.
interface jtag_chain_master_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             jen;
    logic [WIDTH-1:0] jin;
    logic [WIDTH-1:0] jout;

    modport master (
        input  in_data, in_valid, out_ready, jout,
        output in_ready, out_data, out_valid, jen, jin
    );

    modport slave (
        output in_data, in_valid, out_ready, jout,
        input  in_ready, out_data, out_valid, jen, jin
    );
endinterface

// File: rtl/jtag_chain_master.sv
// Streams an image through the Imem/Dmem word chain, returning displaced words; CHAIN_LEN+3 cycles per pass.
// Backpressure: an in_valid gap or a held out word freezes the chain (Jen=0) and the shift counter.
module jtag_chain_master #(
    parameter int WIDTH     = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             recirc_i,
    jtag_chain_master_if.master bus,
    output logic             busy_o,
    output logic             cpu_rst_o,
    output logic             done_o,
    output logic [CNT_W-1:0] shift_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

    state_e           state_q, state_d;
    logic             recirc_q, recirc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             shift_go;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            recirc_q    <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            recirc_q    <= recirc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        recirc_d    = recirc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        shift_go    = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    recirc_d = recirc_i;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DRAIN;
                end else begin
                    shift_go = (recirc_q | bus.in_valid) & (~out_valid_q | bus.out_ready);
                end
                // The captured word is the tail before this edge's shift moves it on.
                if (shift_go) begin
                    out_data_d  = bus.jout;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || bus.out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.jen       = shift_go;
    assign bus.in_ready  = shift_go & ~recirc_q;
    assign bus.jin       = recirc_q ? bus.jout : bus.in_data;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_DRAIN);
    assign cpu_rst_o   = busy_o;
    assign done_o      = (state_q == S_DONE);
    assign shift_cnt_o = cnt_q;
endmodule

// File: tb/tb_jtag_chain_master.sv
// Directed bench for jtag_chain_master with a behavioural 1024-word chain model.
module tb_jtag_chain_master;
    localparam int WIDTH = 32;
    localparam int LEN   = 1024;
    localparam int CW    = 11;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          start  = 1'b0;
    logic          recirc = 1'b0;
    logic          busy;
    logic          cpu_rst;
    logic          done;
    logic [CW-1:0] shift_cnt;

    jtag_chain_master_if #(.WIDTH(WIDTH)) bus ();

    jtag_chain_master #(.WIDTH(WIDTH), .CHAIN_LEN(LEN), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .recirc_i    (recirc),
        .bus         (bus),
        .busy_o      (busy),
        .cpu_rst_o   (cpu_rst),
        .done_o      (done),
        .shift_cnt_o (shift_cnt)
    );

    always #5 clk = ~clk;

    // Chain model: index 0 is Imem[0] (head), index LEN-1 is Dmem[511] (tail).
    logic [WIDTH-1:0] chain [0:LEN-1];
    logic             chain_init = 1'b0;

    always @(posedge clk) begin
        if (chain_init) begin
            for (int i = 0; i < LEN; i++) chain[i] <= 32'h5000_0000 | 32'(i);
        end else if (bus.jen) begin
            for (int i = LEN - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= bus.jin;
        end
    end

    assign bus.jout = chain[LEN-1];

    int errors = 0;
    int checks = 0;

    logic [31:0] got [0:LEN-1];
    int n_got, done_cyc, busy_first, busy_last, jen_first, jen_last, jen_cnt;
    bit fin_flag, aborted, gap_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // pat: 0 full rate, 1 out_ready toggling, 2 input gap at 300, 3 reset at 500, 4 stray start at 100
    task automatic run_pass(input bit rc, input int pat, input logic [31:0] base);
        int cyc = 0;
        int in_idx = 0;
        int gap = 0;
        n_got = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
        jen_first = -1; jen_last = -1; jen_cnt = 0;
        fin_flag = 0; aborted = 0; gap_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        recirc = rc;
        bus.in_valid = ~rc;
        bus.in_data = base;
        bus.out_ready = 1'b1;
        while (!fin_flag && cyc < 4000) begin
            @(negedge clk);
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            check("cpu_rst_eq_busy", cpu_rst, busy);
            check("in_ready_rule", bus.in_ready, bus.jen & ~rc);
            if (bus.out_valid && !bus.out_ready) check("stall_jen", bus.jen, 0);
            if (cyc == 1) check("cnt_cleared_at_start", shift_cnt, 0);
            if (pat == 4 && cyc == 101) check("stray_start_ignored", shift_cnt, 100);
            if (gap > 0) begin
                check("gap_jen", bus.jen, 0);
                check("gap_in_ready", bus.in_ready, 0);
                check("gap_cnt", shift_cnt, 300);
                gap--;
            end
            if (bus.jen) begin
                jen_cnt++;
                if (jen_first < 0) jen_first = cyc;
                jen_last = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (n_got < LEN) got[n_got] = bus.out_data;
                n_got++;
            end
            if (bus.in_ready) in_idx++;
            if (done) begin
                done_cyc = cyc;
                fin_flag = 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 0) recirc = ~rc;
            cyc++;
            bus.in_data = base + 32'(in_idx);
            if (pat == 1) bus.out_ready = (cyc % 2 == 0);
            if (pat == 2 && !gap_seen && shift_cnt == 11'd300) begin
                gap = 5;
                gap_seen = 1;
            end
            bus.in_valid = ~rc && (gap == 0);
            if (pat == 4 && cyc == 100) start = 1'b1;
            if (pat == 3 && !aborted && shift_cnt == 11'd500) begin
                rst_n = 1'b0;
                #1;
                check("abort_jen", bus.jen, 0);
                check("abort_busy", busy, 0);
                check("abort_cpu_rst", cpu_rst, 0);
                check("abort_out_valid", bus.out_valid, 0);
                check("abort_done", done, 0);
                check("abort_cnt", shift_cnt, 0);
                #2;
                rst_n = 1'b1;
                aborted = 1;
                fin_flag = 1;
            end
        end
        if (pat != 3) check("pass_finished", fin_flag, 1);
        start = 1'b0;
        recirc = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic check_pass(input string tag, input bit timing, input bit stream,
                              input logic [31:0] base, input bit desc);
        int bad = 0;
        logic [31:0] exp;
        check({tag, "_jen_cnt"}, jen_cnt, LEN);
        check({tag, "_out_cnt"}, n_got, LEN);
        check({tag, "_final_cnt"}, shift_cnt, LEN);
        if (timing) begin
            check({tag, "_done_cyc"}, done_cyc, LEN + 3);
            check({tag, "_busy_first"}, busy_first, 1);
            check({tag, "_busy_last"}, busy_last, LEN + 2);
            check({tag, "_jen_first"}, jen_first, 1);
            check({tag, "_jen_last"}, jen_last, LEN);
        end
        if (stream) begin
            for (int k = 0; k < LEN; k++) begin
                exp = desc ? (base | 32'(LEN - 1 - k)) : (base + 32'(k));
                if (got[k] !== exp) bad++;
            end
            check({tag, "_stream_bad_words"}, bad, 0);
            check({tag, "_first_word"}, got[0], desc ? (base | 32'(LEN - 1)) : base);
            check({tag, "_last_word"}, got[LEN-1], desc ? base : (base + 32'(LEN - 1)));
        end
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chain_init = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_jen", bus.jen, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_rst", cpu_rst, 0);
        check("rst_done", done, 0);
        check("rst_shift_cnt", shift_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        chain_init = 1'b0;
        rst_n = 1'b1;

        // Load 0..1023 over the initial contents.
        run_pass(1'b0, 0, 32'h0);
        check_pass("t1", 1, 1, 32'h5000_0000, 1);

        // Two recirculating readbacks return the same stream.
        run_pass(1'b1, 0, 32'h0);
        check_pass("t2a", 1, 1, 32'h0, 0);
        run_pass(1'b1, 0, 32'h0);
        check_pass("t2b", 1, 1, 32'h0, 0);

        run_pass(1'b0, 0, 32'hA000);
        check_pass("t3load", 1, 1, 32'h0, 0);
        run_pass(1'b1, 0, 32'h0);
        check_pass("t3rc", 1, 1, 32'hA000, 0);

        run_pass(1'b0, 1, 32'hB000);
        check_pass("t4", 0, 1, 32'hA000, 0);

        run_pass(1'b0, 2, 32'hD000);
        check("t5_gap_seen", gap_seen, 1);
        check_pass("t5", 0, 1, 32'hB000, 0);
        run_pass(1'b1, 0, 32'h0);
        check_pass("t5rc", 1, 1, 32'hD000, 0);

        run_pass(1'b0, 3, 32'hE000);
        check("t6_aborted", aborted, 1);
        check("t6_jen_before_abort", jen_cnt, 500);
        run_pass(1'b0, 4, 32'hC000);
        check_pass("t6load", 1, 0, 32'h0, 0);
        run_pass(1'b1, 0, 32'h0);
        check_pass("t6rc", 1, 1, 32'hC000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
